// File: rtl/mac_pkg.sv
// Shared types and default widths for the mac_accum_8 multiply-accumulate stage.
package mac_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } mac_state_e;

    localparam int MAC_ACC_W = 24;
    localparam int MAC_CNT_W = 16;

endpackage

// File: rtl/multiply8bits.sv
// Combinational unsigned 8x8 multiplier built from shifted partial products.
module multiply8bits (
    output logic [15:0] product,
    input  logic [7:0]  inp1,
    input  logic [7:0]  inp2
);

    logic [15:0] pp [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pp
            assign pp[gi] = inp2[gi] ? (16'(inp1) << gi) : 16'd0;
        end
    endgenerate

    always_comb begin
        product = '0;
        for (int i = 0; i < 8; i++) begin
            product = product + pp[i];
        end
    end

endmodule

// File: rtl/mac_accum_8.sv
// Two-stage operand/product pipeline feeding a wide accumulator; emits one
// dot-product result per in_last-terminated vector over a valid/ready port.
module mac_accum_8
    import mac_pkg::*;
#(
    parameter int ACC_W = MAC_ACC_W,
    parameter int CNT_W = MAC_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       inp1,
    input  logic [7:0]       inp2,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    mac_state_e        state_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [ACC_W-1:0]  out_data_q;
    logic [CNT_W-1:0]  out_count_q;
    logic              out_ovf_q;

    logic              s1_valid_q;
    logic [7:0]        s1_a_q;
    logic [7:0]        s1_b_q;
    logic              s1_last_q;

    logic              s2_valid_q;
    logic [15:0]       s2_prod_q;
    logic              s2_last_q;

    logic [ACC_W-1:0]  acc_q,  acc_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    logic              ovf_q,  ovf_d;

    logic              accept;
    logic              last_done;
    logic [15:0]       mult_prod;
    logic [ACC_W:0]    sum_w;
    logic [ACC_W-1:0]  acc_sum;
    logic [CNT_W-1:0]  cnt_inc;
    logic              ovf_new;

    multiply8bits u_mult (
        .product (mult_prod),
        .inp1    (s1_a_q),
        .inp2    (s1_b_q)
    );

    assign accept    = in_valid && in_ready_q;
    assign last_done = s2_valid_q && s2_last_q;

    // Extra top bit of the sum captures the carry that feeds the sticky flag.
    assign sum_w   = {1'b0, acc_q} + {1'b0, ACC_W'(s2_prod_q)};
    assign acc_sum = sum_w[ACC_W-1:0];
    assign ovf_new = ovf_q | sum_w[ACC_W];
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (s2_valid_q) begin
            if (s2_last_q) begin
                acc_d = '0;
                cnt_d = '0;
                ovf_d = 1'b0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_inc;
                ovf_d = ovf_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_prod_q  <= '0;
            s2_last_q  <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_a_q    <= inp1;
                s1_b_q    <= inp2;
                s1_last_q <= in_last;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_prod_q <= mult_prod;
                s2_last_q <= s1_last_q;
            end
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // The result is captured from the live sum, so the final product never
    // needs to land in acc_q before being presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept && in_last) begin
                        state_q    <= DRAIN;
                        in_ready_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (last_done) begin
                        state_q     <= HOLD;
                        out_valid_q <= 1'b1;
                        out_data_q  <= acc_sum;
                        out_count_q <= cnt_inc;
                        out_ovf_q   <= ovf_new;
                    end
                end
                HOLD: begin
                    if (out_valid_q && out_ready) begin
                        state_q     <= ACCUM;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ACCUM;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mac_accum_8.sv
// Randomized scoreboard bench for mac_accum_8 with directed latency,
// backpressure, wrap/overflow and mid-vector reset scenarios.
module tb_mac_accum_8;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  inp1;
    logic [7:0]  inp2;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic [15:0] out_count;
    logic        out_ovf;

    mac_accum_8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inp1      (inp1),
        .inp2      (inp2),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] data;
        logic [15:0] count;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   vec_a[$];
    int   vec_b[$];
    int   checks = 0;
    int   failures = 0;
    int   results_seen = 0;
    int   vectors_issued = 0;
    bit   rand_ready_en = 0;

    // Reference: plain integer dot product, reduced to the output widths.
    function automatic exp_t model_vector();
        exp_t   e;
        longint sum;
        int     n;
        sum = 0;
        n   = vec_a.size();
        for (int i = 0; i < n; i++) sum += longint'(vec_a[i]) * longint'(vec_b[i]);
        e.data  = 24'(sum % (longint'(1) << 24));
        e.ovf   = (sum >= (longint'(1) << 24));
        e.count = (n > 65535) ? 16'hFFFF : 16'(n);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got data=%0d count=%0d ovf=%0d, required no result",
                         out_data, out_count, out_ovf);
            end else begin
                e = exp_q.pop_front();
                results_seen++;
                $display("RESULT #%0d data=%0d count=%0d ovf=%0d (exp %0d/%0d/%0d)",
                         results_seen, out_data, out_count, out_ovf, e.data, e.count, e.ovf);
                checks++;
                if (out_data !== e.data) begin
                    failures++;
                    $display("FAIL out_data: got %0d, required %0d", out_data, e.data);
                end
                checks++;
                if (out_count !== e.count) begin
                    failures++;
                    $display("FAIL out_count: got %0d, required %0d", out_count, e.count);
                end
                checks++;
                if (out_ovf !== e.ovf) begin
                    failures++;
                    $display("FAIL out_ovf: got %0d, required %0d", out_ovf, e.ovf);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready_en) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic check1(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_pair(input int a, input int b, input bit last);
        bit rdy;
        int waitc;
        in_valid = 1'b1;
        inp1     = 8'(a);
        inp2     = 8'(b);
        in_last  = last;
        waitc    = 0;
        rdy      = 1'b0;
        while (!rdy && waitc < 300) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            waitc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!rdy) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, required 1", waitc);
        end
    endtask

    task automatic send_vector(input int max_gap, input bit terminate);
        if (terminate) begin
            exp_q.push_back(model_vector());
            vectors_issued++;
        end
        for (int i = 0; i < vec_a.size(); i++) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk);
                #1;
            end
            send_pair(vec_a[i], vec_b[i], terminate && (i == vec_a.size() - 1));
        end
    endtask

    task automatic wait_results();
        int c;
        c = 0;
        while (results_seen < vectors_issued && c < 3000) begin
            @(posedge clk);
            #1;
            c++;
        end
        check1("result_wait", results_seen, vectors_issued);
    endtask

    task automatic fill_const(input int n, input int a, input int b);
        vec_a.delete();
        vec_b.delete();
        for (int i = 0; i < n; i++) begin
            vec_a.push_back(a);
            vec_b.push_back(b);
        end
    endtask

    initial begin
        logic [23:0] held;
        int c;
        rst = 1'b1; in_valid = 1'b0; inp1 = '0; inp2 = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check1("reset_in_ready", 32'(in_ready), 1);
        check1("reset_out_valid", 32'(out_valid), 0);
        check1("reset_out_data", 32'(out_data), 0);
        check1("reset_out_count", 32'(out_count), 0);
        check1("reset_out_ovf", 32'(out_ovf), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Latency / in_ready timing on the basic vector.
        vec_a = '{40, 10, 40};
        vec_b = '{150, 150, 150};
        send_vector(0, 1);
        check1("in_ready_falls", 32'(in_ready), 0);
        check1("valid_at_E", 32'(out_valid), 0);
        @(posedge clk); #1;
        check1("valid_at_E1", 32'(out_valid), 0);
        @(posedge clk); #1;
        check1("valid_at_E2", 32'(out_valid), 1);
        @(posedge clk); #1;
        check1("in_ready_rises", 32'(in_ready), 1);
        check1("valid_dropped", 32'(out_valid), 0);
        wait_results();

        vec_a = '{3};   vec_b = '{5};   send_vector(0, 1);
        vec_a = '{255}; vec_b = '{255}; send_vector(0, 1);
        fill_const(258, 255, 255); send_vector(0, 1);
        fill_const(259, 255, 255); send_vector(0, 1);
        wait_results();

        // Backpressure: result must hold while in_valid is offered and refused.
        out_ready = 1'b0;
        vec_a = '{7, 200}; vec_b = '{9, 13};
        send_vector(0, 1);
        c = 0;
        while (!out_valid && c < 20) begin @(posedge clk); #1; c++; end
        check1("bp_valid_seen", 32'(out_valid), 1);
        held = out_data;
        in_valid = 1'b1; inp1 = 8'd99; inp2 = 8'd99; in_last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (!(out_valid === 1'b1 && out_data === held && in_ready === 1'b0)) begin
                failures++;
                $display("FAIL hold_stable cycle %0d: got valid=%0d data=%0d in_ready=%0d, required 1/%0d/0",
                         i, out_valid, out_data, in_ready, held);
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check1("bp_in_ready_after_pulse", 32'(in_ready), 1);
        check1("bp_valid_after_pulse", 32'(out_valid), 0);
        repeat (5) @(posedge clk);
        #1;
        check1("hold_offer_not_accepted", 32'(out_valid), 0);
        out_ready = 1'b1;
        wait_results();

        // Bubbles within a vector.
        vec_a = '{1, 3, 5, 7, 9}; vec_b = '{2, 4, 6, 8, 10};
        send_vector(3, 1);
        wait_results();

        // Mid-vector reset, then a clean vector.
        vec_a = '{100, 200}; vec_b = '{50, 60};
        send_vector(0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check1("rst_mid_in_ready", 32'(in_ready), 1);
        check1("rst_mid_out_valid", 32'(out_valid), 0);
        check1("rst_mid_out_data", 32'(out_data), 0);
        check1("rst_mid_out_count", 32'(out_count), 0);
        check1("rst_mid_out_ovf", 32'(out_ovf), 0);
        vec_a = '{2}; vec_b = '{2};
        send_vector(0, 1);
        wait_results();

        // Random vectors with random bubbles and random consumer backpressure.
        rand_ready_en = 1;
        for (int v = 0; v < 12; v++) begin
            int n;
            n = $urandom_range(1, 24);
            vec_a.delete();
            vec_b.delete();
            for (int i = 0; i < n; i++) begin
                vec_a.push_back($urandom_range(0, 255));
                vec_b.push_back($urandom_range(0, 255));
            end
            send_vector(2, 1);
        end
        wait_results();
        rand_ready_en = 0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check1("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_accum_8.md
# mac_accum_8

Sequential multiply-accumulate stage sitting directly downstream of the combinational 8-bit multiplier `multiply8bits`. It accepts a stream of 8-bit operand pairs over a valid/ready handshake and registers each pair. It feeds each pair through one `multiply8bits` instance and sums the 16-bit products into a wide accumulator. On the pair flagged `in_last`, it presents the dot-product result over an output valid/ready handshake.

## Interface
Parameters:
- `ACC_W`, 24: accumulator and result width; must be ≥ 16.
- `CNT_W`, 16: term-counter width.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: operand pair present.
- `in_ready`, output, 1: stage can accept a pair.
- `inp1`, input, 8: unsigned multiplicand.
- `inp2`, input, 8: unsigned multiplier.
- `in_last`, input, 1: this pair ends the current vector.
- `out_valid`, output, 1: result present.
- `out_ready`, input, 1: consumer accepts the result.
- `out_data`, output, ACC_W: sum of products, modulo 2^ACC_W.
- `out_count`, output, CNT_W: number of pairs in the vector, saturating.
- `out_ovf`, output, 1: sticky flag, set if any accumulation carried out of ACC_W bits.

## Operation
- A pair is accepted on an edge where `in_valid && in_ready`. Inputs are ignored on all other edges.
- Pipeline:
  - S1 registers `inp1`, `inp2` and `in_last` with a valid bit.
  - S2 registers the 16-bit `multiply8bits` product of the S1 operands, plus the last flag and valid bit.
  - The accumulate step adds the zero-extended S2 product to `acc`.
- FSM states:
  - ACCUM: `in_ready`=1. Accepting a pair with `in_last`=1 moves to DRAIN.
  - DRAIN: `in_ready`=0. Waits for the last pair to leave S2. On that edge it loads `out_data` = `acc` + product, `out_count` and `out_ovf`; sets `out_valid`; clears `acc`, the counter and the overflow flag; moves to HOLD.
  - HOLD: `in_ready`=0, `out_valid`=1. Outputs stay stable until `out_valid && out_ready`, then it returns to ACCUM with `out_valid`=0.
- Arithmetic:
  - The sum is ACC_W bits wide and wraps on overflow; any carry out sets the sticky overflow flag.
  - The counter increments per accumulated product and saturates at 2^CNT_W−1.
- A vector of length 1 (first pair has `in_last`) is legal.
- A vector of zero pairs cannot occur; results are produced only on `in_last`.

## Timing
- Reset values:
  - `in_ready`=1; `out_valid`=0; `out_data`=0; `out_count`=0; `out_ovf`=0.
  - `acc`=0; S1/S2 valid bits=0; state=ACCUM.
- Reset mid-operation discards all in-flight pairs and any held result. `rst` overrides every handshake on the same edge.
- Throughput: one pair per cycle while in ACCUM.
- Latency: `in_last` accepted at edge E gives `out_valid`=1 immediately after edge E+2.
- `in_ready` falls immediately after the `in_last` accept edge. It rises immediately after the edge where `out_valid && out_ready`; there is no bypass in the same cycle.
- `out_ready` is ignored while `out_valid`=0.
- `in_valid` may drop at any time in ACCUM; gaps (bubbles) do not affect the sum.

## Structure
- Package `mac_pkg`:
  - State enum {ACCUM, DRAIN, HOLD}.
  - Default constants `MAC_ACC_W`=24 and `MAC_CNT_W`=16.
- One sub-module: the existing `multiply8bits`, instantiated once between S1 and S2. Port order is (product, inp1, inp2). No other sub-modules.

## Test plan
- Vector (40,150),(10,150),(40,150 last) → `out_data`=13500, `out_count`=3, `out_ovf`=0. `out_valid` asserts 2 cycles after the last accept.
- Single pair (3,5 last) → `out_data`=15, `out_count`=1. Then (255,255 last) → 65025, with `acc` confirmed cleared between vectors.
- 258 pairs of (255,255) → 16776450, `out_ovf`=0. 259 pairs → `out_data`=64259, `out_ovf`=1, `out_count`=259.
- Backpressure:
  - Hold `out_ready`=0 for 10 cycles: `out_valid` and data stay stable, `in_ready`=0.
  - Pulse `out_ready`: `in_ready`=1 on the next cycle.
  - `in_valid` offered during HOLD is not accepted.
- Random `in_valid` bubbles over a 5-pair vector with (1,2),(3,4),(5,6),(7,8),(9,10 last) → 190, `out_count`=5.
- Assert `rst` one cycle after accepting 2 pairs of a vector:
  - All outputs return to reset values.
  - A following vector (2,2 last) yields 4 with no residue.
